// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage forwarding selects and load-use stall control for a 5-stage MIPS pipeline
//   clk, rst_n         : rising-edge clock, asynchronous active-low reset
//   id_*               : decode-stage instruction fields (sources, destination, control)
//   hold_in            : global freeze, every register holds
//   flush              : squash the ID instruction (bubble into EX)
//   forward_a/b        : registered EX mux selects (10 EX/MEM, 01 MEM/WB, 00 register bus)
//   ex_mem_write       : EX instruction is a store
//   stall_out          : combinational load-use stall for PC and IF/ID
//   stall_count        : saturating count of load-use stalls
module fwd_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       id_dest,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             hold_in,
   input  logic             flush,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             ex_mem_write,
   output logic             stall_out,
   output logic [CNT_W-1:0] stall_count
);
   logic       ex_valid, ex_rw, ex_mr, mem_valid, mem_rw;
   logic [4:0] ex_dest, mem_dest;
   logic       ex_a, ex_b, mem_a, mem_b;
   logic [1:0] sel_a, sel_b;

   // register 0 is hardwired, so a slot never produces it
   function automatic logic prod(input logic v, input logic w, input logic [4:0] d, input logic [4:0] r);
      return v & w & (d == r) & (r != 5'd0);
   endfunction

   assign ex_a  = prod(ex_valid, ex_rw, ex_dest, id_rs);
   assign ex_b  = prod(ex_valid, ex_rw, ex_dest, id_rt);
   assign mem_a = prod(mem_valid, mem_rw, mem_dest, id_rs);
   assign mem_b = prod(mem_valid, mem_rw, mem_dest, id_rt);

   // EX slot checked first: the newest producer wins
   assign sel_a = !(id_valid & id_use_rs) ? 2'b00 : ex_a ? 2'b10 : mem_a ? 2'b01 : 2'b00;
   assign sel_b = !(id_valid & id_use_rt) ? 2'b00 : ex_b ? 2'b10 : mem_b ? 2'b01 : 2'b00;

   assign stall_out = id_valid & !flush & ex_valid & ex_mr & ((id_use_rs & ex_a) | (id_use_rt & ex_b));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ex_valid     <= 1'b0;
         ex_rw        <= 1'b0;
         ex_mr        <= 1'b0;
         ex_dest      <= 5'd0;
         mem_valid    <= 1'b0;
         mem_rw       <= 1'b0;
         mem_dest     <= 5'd0;
         forward_a    <= 2'b00;
         forward_b    <= 2'b00;
         ex_mem_write <= 1'b0;
         stall_count  <= '0;
      end else if (!hold_in) begin
         mem_valid <= ex_valid;
         mem_rw    <= ex_rw;
         mem_dest  <= ex_dest;
         if (flush | stall_out) begin
            ex_valid     <= 1'b0;
            ex_rw        <= 1'b0;
            ex_mr        <= 1'b0;
            ex_dest      <= 5'd0;
            forward_a    <= 2'b00;
            forward_b    <= 2'b00;
            ex_mem_write <= 1'b0;
         end else begin
            ex_valid     <= id_valid;
            ex_rw        <= id_reg_write;
            ex_mr        <= id_mem_read;
            ex_dest      <= id_dest;
            forward_a    <= sel_a;
            forward_b    <= sel_b;
            ex_mem_write <= id_valid & id_mem_write;
         end
         if (stall_out && !(&stall_count))
            stall_count <= stall_count + 1'b1;
      end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: scoreboard bench for fwd_hazard_ctrl with directed instruction sequences
module tb_fwd_hazard_ctrl;
   localparam int CW = 4;

   typedef struct {
      logic       v;
      logic [4:0] rs, rt, d;
      logic       urs, urt, rw, mr, mw;
   } ins_t;

   typedef struct {
      logic [1:0] fa, fb;
      logic       mw, st;
      int         cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic [4:0]    id_rs = '0, id_rt = '0, id_dest = '0;
   logic          id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
   logic          hold_in = 1'b0, flush = 1'b0;
   logic [1:0]    forward_a, forward_b;
   logic          ex_mem_write, stall_out;
   logic [CW-1:0] stall_count;

   exp_t q[$];
   exp_t e;
   int   n_chk = 0, n_fail = 0, cyc_n = 0;

   fwd_hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .hold_in(hold_in), .flush(flush), .forward_a(forward_a), .forward_b(forward_b),
      .ex_mem_write(ex_mem_write), .stall_out(stall_out), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   function automatic ins_t mk(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                               input int d, input logic rw, input logic mr, input logic mw);
      ins_t x;
      x.v = v; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt;
      x.d = 5'(d); x.rw = rw; x.mr = mr; x.mw = mw;
      return x;
   endfunction

   function automatic ins_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic ins_t alu(input int d, input int s, input int t);
      return mk(1, s, t, 1, 1, d, 1, 0, 0);
   endfunction
   function automatic ins_t lw(input int d, input int b);
      return mk(1, b, 0, 1, 0, d, 1, 1, 0);
   endfunction
   function automatic ins_t sw(input int b, input int t);
      return mk(1, b, t, 1, 1, 0, 0, 0, 1);
   endfunction

   // drive one cycle of ID inputs and queue the outputs expected during that cycle
   task automatic cyc(input ins_t i, input logic [1:0] fa, input logic [1:0] fb, input logic mw,
                      input logic st, input int cnt, input logic h = 0, input logic f = 0, input logic r = 0);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n = !r;
      id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_use_rs = i.urs; id_use_rt = i.urt;
      id_dest = i.d; id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw;
      hold_in = h; flush = f;
      x.fa = fa; x.fb = fb; x.mw = mw; x.st = st; x.cnt = cnt;
      q.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc_n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc_n++;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("forward_a", 32'(forward_a), 32'(e.fa));
         chk("forward_b", 32'(forward_b), 32'(e.fb));
         chk("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
         chk("stall_out", 32'(stall_out), 32'(e.st));
         chk("stall_count", 32'(stall_count), 32'(e.cnt));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(nop(), 0, 0, 0, 0, 0, 0, 0, 1);
      // EX-to-EX forward
      cyc(alu(3, 1, 2), 0, 0, 0, 0, 0);
      cyc(alu(6, 3, 8), 0, 0, 0, 0, 0);
      cyc(nop(),        2'b10, 0, 0, 0, 0);
      // MEM forward on rt
      cyc(alu(9, 1, 1), 0, 0, 0, 0, 0);
      cyc(nop(),        0, 0, 0, 0, 0);
      cyc(alu(10, 2, 9), 0, 0, 0, 0, 0);
      cyc(nop(),        0, 2'b01, 0, 0, 0);
      // load-use stall then MEM forward
      cyc(lw(5, 1),      0, 0, 0, 0, 0);
      cyc(alu(11, 5, 2), 0, 0, 0, 1, 0);
      cyc(alu(11, 5, 2), 0, 0, 0, 0, 1);
      cyc(nop(),         2'b01, 0, 0, 0, 1);
      // register 0 never forwarded; load behind ALU producer of the same register stalls
      cyc(alu(0, 1, 1),  0, 0, 0, 0, 1);
      cyc(alu(12, 0, 0), 0, 0, 0, 0, 1);
      cyc(alu(4, 1, 1),  0, 0, 0, 0, 1);
      cyc(lw(4, 1),      0, 0, 0, 0, 1);
      cyc(alu(13, 4, 4), 0, 0, 0, 1, 1);
      cyc(alu(13, 4, 4), 0, 0, 0, 0, 2);
      cyc(nop(),         2'b01, 2'b01, 0, 0, 2);
      // store data forward
      cyc(alu(7, 1, 1), 0, 0, 0, 0, 2);
      cyc(sw(2, 7),     0, 0, 0, 0, 2);
      cyc(nop(),        0, 2'b10, 1, 0, 2);
      // flush squashes the store and masks a load-use stall
      cyc(alu(7, 1, 1),  0, 0, 0, 0, 2);
      cyc(sw(2, 7),      0, 0, 0, 0, 2, 0, 1);
      cyc(nop(),         0, 0, 0, 0, 2);
      cyc(lw(5, 1),      0, 0, 0, 0, 2);
      cyc(alu(11, 5, 2), 0, 0, 0, 0, 2, 0, 1);
      cyc(nop(),         0, 0, 0, 0, 2);
      // hold during a load-use stall
      cyc(lw(5, 1),      0, 0, 0, 0, 2);
      cyc(alu(11, 5, 5), 0, 0, 0, 1, 2, 1);
      cyc(alu(11, 5, 5), 0, 0, 0, 1, 2, 1);
      cyc(alu(11, 5, 5), 0, 0, 0, 1, 2);
      cyc(alu(11, 5, 5), 0, 0, 0, 0, 3);
      cyc(nop(),         2'b01, 2'b01, 0, 0, 3, 1);
      cyc(nop(),         2'b01, 2'b01, 0, 0, 3);
      cyc(nop(),         0, 0, 0, 0, 3);
      // EX beats MEM for the same register
      cyc(alu(4, 1, 1),    0, 0, 0, 0, 3);
      cyc(alu(4, 2, 2),    0, 0, 0, 0, 3);
      cyc(alu(14, 4, 1),   0, 0, 0, 0, 3);
      cyc(alu(16, 14, 14), 2'b10, 0, 0, 0, 3);
      // asynchronous reset mid-run, then normal update after release
      cyc(nop(),        0, 0, 0, 0, 0, 0, 0, 1);
      cyc(alu(3, 1, 1), 0, 0, 0, 0, 0);
      cyc(alu(6, 3, 8), 0, 0, 0, 0, 0);
      cyc(nop(),        2'b10, 0, 0, 0, 0);
      cyc(nop(),        0, 0, 0, 0, 0);
      // counter saturation
      for (int i = 0; i < 17; i++) begin
         cyc(lw(5, 1),      0, 0, 0, 0, i < 15 ? i : 15);
         cyc(alu(11, 5, 2), 0, 0, 0, 1, i < 15 ? i : 15);
         cyc(alu(11, 5, 2), 0, 0, 0, 0, i + 1 < 15 ? i + 1 : 15);
         cyc(nop(),         2'b01, 0, 0, 0, i + 1 < 15 ? i + 1 : 15);
      end
      for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline; it generates the 2-bit Forward selects and MemWrite qualifier that drive the EX-stage forwarding muxes. It sits beside the ID stage, compares the decoding instruction's sources against a shadow copy of the destinations in flight in EX and MEM, and registers the selects into EX together with the instruction. It also raises a one-cycle load-use stall and keeps a saturating count of such stalls.

## Interface
- CNT_W, 16, width of the load-use stall counter

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  source register A of the ID instruction
- id_rt  in  5  source register B of the ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt (includes store data)
- id_dest  in  5  destination register of the ID instruction
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- id_mem_write  in  1  ID instruction is a store
- hold_in  in  1  global freeze (memory wait); all state holds
- flush  in  1  branch taken; the ID instruction is squashed
- forward_a  out  2  EX select for operand A: 10 = EX/MEM result, 01 = MEM/WB result, 00 = register bus
- forward_b  out  2  same encoding for operand B / store data
- ex_mem_write  out  1  EX instruction is a store (mux routes forwarded value to data path only)
- stall_out  out  1  freeze PC and IF/ID, bubble into EX (combinational)
- stall_count  out  CNT_W  number of load-use stalls, saturating

## Operation
- Shadow slots: ex_slot {valid, dest, reg_write, mem_read} = instruction now in EX; mem_slot {valid, dest, reg_write} = instruction now in MEM.
- A slot "produces r" when valid & reg_write & dest == r & r != 0. Register 0 is never forwarded.
- Select for source r (only if its use bit and id_valid are set, else 00):
  - ex_slot produces r -> 10 (newest value wins).
  - else mem_slot produces r -> 01.
  - else 00. Encoding 11 is never generated.
- Load-use: stall_out = id_valid & !flush & ex_slot.valid & ex_slot.mem_read & ex_slot produces (id_rs if id_use_rs) or (id_rt if id_use_rt).
- Register-file write-first-half covers the WB-to-ID distance; no third forwarding source.
- Per-cycle update, priority hold_in > flush > stall_out > normal:
  - hold_in: every register holds.
  - flush: ex_slot <= bubble, mem_slot <= ex_slot, forward_a/b <= 00, ex_mem_write <= 0.
  - stall_out: same bubble insertion as flush; stall_count += 1 unless all ones. ID instruction is re-presented next cycle and then sees the load in mem_slot -> 01.
  - normal: ex_slot <= ID fields (valid = id_valid), mem_slot <= ex_slot, forward_a/b <= computed selects, ex_mem_write <= id_valid & id_mem_write.
- Reset (async, rst_n low): both slots invalid, forward_a = forward_b = 00, ex_mem_write = 0, stall_count = 0; stall_out therefore 0.

## Timing
- Selects computed in ID, registered on the edge the instruction enters EX: zero-cycle lag at the muxes.
- stall_out valid same cycle as ID inputs; exactly one stall cycle per load-use pair (two when hold_in intervenes, stall persists through hold).
- Back-to-back producers of the same register: EX wins over MEM.
- Reset deassertion mid-stream: first edge after release performs a normal update.

## Test plan
- add $3 then sub using $3 as rs, no gap -> forward_a = 10, forward_b = 00 in sub's EX cycle, stall_out 0.
- add $3, nop, or using $3 as rt -> forward_b = 01 in or's EX cycle.
- lw $5 then add using $5 -> stall_out 1 for one cycle, stall_count 0->1, bubble in EX (selects 00), next cycle forward_a = 01.
- add $0 followed by reader of $0 -> selects 00; add $4 and lw $4 consecutively then reader of $4 -> 10 from the lw slot forces stall first.
- sw with rt = $7 after add $7 -> forward_b = 10, ex_mem_write = 1; flush asserted with same stimulus -> selects 00, ex_mem_write 0, no stall.
- hold_in during load-use -> all outputs frozen, stall_count increments once; drive 65535 stalls -> counter saturates at 0xFFFF; rst_n low mid-run -> all outputs 0 immediately.
